alu_seq: RTL

- Parametrised, handshaked successor to the datapath ALU for the next-generation multi-cycle core.
- Widens the operation set beyond add/sub/equality to logic ops, shifts and an iterative shift-add multiplier, and adds carry/overflow flags.
- Operands are captured on a valid/ready input handshake; results are held on a valid/ready output handshake until consumed.
- Sits between the register-file/operand MUX and the writeback/branch logic.

---
 rtl/alu_seq.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU. Most opcodes finish in one cycle. MUL runs an
// iterative shift-add over WIDTH cycles. The result is held until the consumer takes it.
module alu_seq #(
    parameter int WIDTH  = 16,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [3:0]       ALUcontrol,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUresult,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_EQ  = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0]        r_count;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_result;
    logic                 r_zero;
    logic                 r_carry;
    logic                 r_overflow;

    logic                 w_accept;
    logic                 w_isMul;
    logic                 w_mulLast;
    logic [2*WIDTH-1:0]   w_accStep;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [SHW-1:0]       w_amt;
    logic [WIDTH-1:0]     w_res;
    logic                 w_zero;
    logic                 w_carry;
    logic                 w_overflow;
    logic                 w_defined;

    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_isMul   = (MUL_EN != 0) && (ALUcontrol == OP_MUL);
    assign w_mulLast = (r_count == CW'(WIDTH - 1));
    assign w_accStep = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    assign w_sum  = {1'b0, data1} + {1'b0, data2};
    assign w_diff = {1'b0, data1} - {1'b0, data2};
    assign w_amt  = data2[SHW-1:0];

    // Single-cycle datapath, evaluated directly on the inputs so the result can be registered at the accept edge
    always_comb begin
        w_res      = '0;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        w_zero     = 1'b0;
        w_defined  = 1'b1;
        case (ALUcontrol)
            OP_ADD: begin
                w_res      = w_sum[WIDTH-1:0];
                w_carry    = w_sum[WIDTH];
                w_overflow = (data1[WIDTH-1] == data2[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != data1[WIDTH-1]);
            end
            OP_SUB: begin
                w_res      = w_diff[WIDTH-1:0];
                w_carry    = w_diff[WIDTH];
                w_overflow = (data1[WIDTH-1] != data2[WIDTH-1]) &&
                             (w_diff[WIDTH-1] != data1[WIDTH-1]);
            end
            OP_AND: w_res = data1 & data2;
            OP_OR:  w_res = data1 | data2;
            OP_XOR: w_res = data1 ^ data2;
            OP_SLL: w_res = data1 << w_amt;
            OP_SRL: w_res = data1 >> w_amt;
            OP_SRA: w_res = WIDTH'($signed(data1) >>> w_amt);
            default: w_defined = 1'b0;
        endcase
        if (ALUcontrol == OP_EQ) begin
            w_zero = (data1 == data2);
        end else if (w_defined) begin
            w_zero = (w_res == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_next = w_isMul ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (w_mulLast) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Result registers only change at accept or at the final multiply step, so they stay frozen in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_count  <= '0;
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, data1};
                        r_mplier <= data2;
                        if (!w_isMul) begin
                            r_result   <= w_res;
                            r_zero     <= w_zero;
                            r_carry    <= w_carry;
                            r_overflow <= w_overflow;
                        end
                    end
                end
                S_MUL: begin
                    r_acc    <= w_accStep;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CW'(1);
                    if (w_mulLast) begin
                        r_result   <= w_accStep[WIDTH-1:0];
                        r_zero     <= (w_accStep[WIDTH-1:0] == '0);
                        r_carry    <= |w_accStep[2*WIDTH-1:WIDTH];
                        r_overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ALUresult = r_result;
    assign zero      = r_zero;
    assign carry     = r_carry;
    assign overflow  = r_overflow;

endmodule
